// File: rtl/ahb_pkg.sv
// Shared AHB encodings and bridge FSM states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// HSIZE + low address bits -> little-endian byte lanes and misalign flag.
module ahb_byte_lane_dec #(
  parameter int DATA_W = 32,
  localparam int BE_W = DATA_W / 8,
  localparam int LW = $clog2(BE_W)
) (
  input  logic [2:0]      size,
  input  logic [LW-1:0]   lo,
  output logic [BE_W-1:0] be,
  output logic            misalign
);
  import ahb_pkg::*;

  typedef logic [LW-1:0] lw_t;

  lw_t ones;
  lw_t mask;

  always_comb begin
    ones = '1;
    mask = ~(ones << size);
    misalign = |(lo & mask);
    be = '0;
    // a lane is on when it falls in the same size-aligned block as lo
    for (int i = 0; i < BE_W; i++) begin
      be[i] = ((lw_t'(i) >> size) == (lo >> size));
    end
  end

endmodule

// File: rtl/ahb_slave_bridge.sv
// AHB slave to simple memory port bridge with wait states and ERROR response.
module ahb_slave_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] SPAN = ADDR_W'(32'h0001_0000),
  parameter int TIMEOUT = 16,
  localparam int BE_W = DATA_W / 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY_IN,
  output logic              HREADY,
  output logic [1:0]        HRESP,
  output logic [15:0]       HSPLIT,
  output logic [DATA_W-1:0] HRDATA,
  output logic              MEnable,
  output logic              MRead,
  output logic              MWrite,
  output logic [ADDR_W-1:0] MAddress,
  output logic [BE_W-1:0]   MByteEn,
  output logic [DATA_W-1:0] MWriteData,
  input  logic [DATA_W-1:0] MReadData,
  input  logic              MReady,
  input  logic              MError
);
  import ahb_pkg::*;

  localparam int LW = $clog2(BE_W);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t state, nxt;

  logic [CW-1:0]     cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;

  logic [BE_W-1:0]   be_d;
  logic              mis_d;
  logic [ADDR_W:0]   lim;
  logic              in_range;
  logic              oversize;
  logic              accept;
  logic              fault;
  logic              adv;
  logic              rd_done;
  logic              cnt_inc;
  logic              unused;

  ahb_byte_lane_dec #(.DATA_W(DATA_W)) u_dec (
    .size     (HSIZE),
    .lo       (HADDR[LW-1:0]),
    .be       (be_d),
    .misalign (mis_d)
  );

  assign lim      = {1'b0, BASE_ADDR} + {1'b0, SPAN};
  assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, HADDR} < lim);
  assign oversize = HSIZE > 3'(LW);
  assign accept   = HSEL && HTRANS[1] && HREADY_IN;
  assign fault    = !in_range || oversize || mis_d;
  assign unused   = ^{HBURST, HTRANS[0]};

  always_comb begin
    nxt     = state;
    HREADY  = 1'b1;
    HRESP   = HRESP_OKAY;
    MEnable = 1'b0;
    adv     = 1'b0;
    rd_done = 1'b0;
    cnt_inc = 1'b0;
    unique case (state)
      IDLE: adv = 1'b1;
      ACCESS: begin
        MEnable = 1'b1;
        if (MReady) begin
          if (MError) begin
            HREADY = 1'b0;
            nxt    = ERR1;
          end else begin
            rd_done = !wr_q;
            adv     = 1'b1;
          end
        end else begin
          HREADY = 1'b0;
          if (TIMEOUT != 0 && cnt == CNT_MAX) nxt = ERR1;
          else cnt_inc = 1'b1;
        end
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
        nxt    = ERR2;
      end
      ERR2: begin
        HRESP = HRESP_ERROR;
        adv   = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    // any completing cycle doubles as the next address phase
    if (adv) begin
      nxt = IDLE;
      if (accept) nxt = fault ? ERR1 : ACCESS;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (adv && accept) begin
        wr_q   <= HWRITE;
        addr_q <= HADDR - BASE_ADDR;
        be_q   <= be_d;
        cnt    <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_done) rdata_q <= MReadData;
    end
  end

  assign MRead      = MEnable && !wr_q;
  assign MWrite     = MEnable && wr_q;
  assign MAddress   = addr_q;
  assign MByteEn    = MEnable ? be_q : '0;
  assign MWriteData = HWDATA;
  assign HRDATA     = rd_done ? MReadData : rdata_q;
  assign HSPLIT     = '0;

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// Directed self-checking bench for ahb_slave_bridge.
module tb_ahb_slave_bridge;
  import ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SPAN = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic [31:0] hrdata;
  logic        menable;
  logic        mread;
  logic        mwrite;
  logic [31:0] maddress;
  logic [3:0]  mbyteen;
  logic [31:0] mwritedata;
  logic [31:0] mreaddata;
  logic        mready;
  logic        merror;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // single-slave bus: the bus-wide HREADY is this slave's own
  assign hready_in = hready;

  ahb_slave_bridge #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .BASE_ADDR (BASE),
    .SPAN      (SPAN),
    .TIMEOUT   (4)
  ) dut (
    .HCLK       (clk),
    .HRESET     (rst),
    .HSEL       (hsel),
    .HTRANS     (htrans),
    .HWRITE     (hwrite),
    .HSIZE      (hsize),
    .HBURST     (hburst),
    .HADDR      (haddr),
    .HWDATA     (hwdata),
    .HREADY_IN  (hready_in),
    .HREADY     (hready),
    .HRESP      (hresp),
    .HSPLIT     (hsplit),
    .HRDATA     (hrdata),
    .MEnable    (menable),
    .MRead      (mread),
    .MWrite     (mwrite),
    .MAddress   (maddress),
    .MByteEn    (mbyteen),
    .MWriteData (mwritedata),
    .MReadData  (mreaddata),
    .MReady     (mready),
    .MError     (merror)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic addr_ph(input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [1:0] tr);
    hsel   = 1'b1;
    htrans = tr;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  initial begin
    logic [31:0] b2b_data [3];
    b2b_data[0] = 32'hA0A0_0000;
    b2b_data[1] = 32'hA1A1_0004;
    b2b_data[2] = 32'hA2A2_0008;

    rst = 1'b1;
    idle_bus();
    hwrite = 1'b0;
    hsize = 3'd0;
    hburst = 3'd0;
    haddr = '0;
    hwdata = '0;
    mreaddata = '0;
    mready = 1'b0;
    merror = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hready", hready, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_menable", menable, 0);
    chk("rst_mbyteen", mbyteen, 0);
    chk("rst_hsplit", hsplit, 0);
    rst = 1'b0;
    nxt_cyc();

    // word write, zero wait
    addr_ph(1, HSIZE_WORD, BASE + 32'h10, HTRANS_NONSEQ);
    mready = 1'b1;
    nxt_cyc();
    idle_bus();
    hwdata = 32'hDEAD_BEEF;
    settle();
    chk("ww_menable", menable, 1);
    chk("ww_mwrite", mwrite, 1);
    chk("ww_mread", mread, 0);
    chk("ww_maddr", maddress, 32'h10);
    chk("ww_be", mbyteen, 4'b1111);
    chk("ww_wdata", mwritedata, 32'hDEAD_BEEF);
    chk("ww_hready", hready, 1);
    chk("ww_hresp", hresp, 0);
    nxt_cyc();
    settle();
    chk("ww_after_men", menable, 0);

    // byte read with three wait states
    addr_ph(0, HSIZE_BYTE, BASE + 32'h3, HTRANS_NONSEQ);
    mready = 1'b0;
    nxt_cyc();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("br_be", mbyteen, 4'b1000);
      chk("br_mread", mread, 1);
      chk("br_wait", hready, 0);
      nxt_cyc();
    end
    mready = 1'b1;
    mreaddata = 32'h1122_3344;
    settle();
    chk("br_done", hready, 1);
    chk("br_hresp", hresp, 0);
    chk("br_hrdata", hrdata, 32'h1122_3344);
    nxt_cyc();
    mreaddata = 32'h0;
    settle();
    chk("br_hold", hrdata, 32'h1122_3344);

    // misaligned word read
    addr_ph(0, HSIZE_WORD, BASE + 32'h2, HTRANS_NONSEQ);
    mready = 1'b1;
    nxt_cyc();
    idle_bus();
    settle();
    chk("mis_e1_men", menable, 0);
    chk("mis_e1_hready", hready, 0);
    chk("mis_e1_hresp", hresp, 1);
    nxt_cyc();
    settle();
    chk("mis_e2_men", menable, 0);
    chk("mis_e2_hready", hready, 1);
    chk("mis_e2_hresp", hresp, 1);
    nxt_cyc();
    settle();
    chk("mis_idle_hresp", hresp, 0);

    // timeout with MReady stuck low
    addr_ph(0, HSIZE_WORD, BASE + 32'h20, HTRANS_NONSEQ);
    mready = 1'b0;
    nxt_cyc();
    idle_bus();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("to_men", menable, 1);
      chk("to_wait", hready, 0);
      nxt_cyc();
    end
    settle();
    chk("to_e1_men", menable, 0);
    chk("to_e1_hready", hready, 0);
    chk("to_e1_hresp", hresp, 1);
    nxt_cyc();
    addr_ph(0, HSIZE_WORD, BASE + 32'h40, HTRANS_IDLE);
    settle();
    chk("to_e2_hready", hready, 1);
    chk("to_e2_hresp", hresp, 1);
    nxt_cyc();
    addr_ph(0, HSIZE_WORD, BASE + 32'h40, HTRANS_BUSY);
    settle();
    chk("to_idle_hresp", hresp, 0);
    chk("to_idle_hready", hready, 1);
    chk("to_idle_men", menable, 0);
    nxt_cyc();
    idle_bus();
    settle();
    chk("busy_men", menable, 0);
    nxt_cyc();

    // back-to-back writes, no bubble
    mready = 1'b1;
    addr_ph(1, HSIZE_WORD, BASE, HTRANS_NONSEQ);
    nxt_cyc();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) addr_ph(1, HSIZE_WORD, BASE + 32'(4 * (i + 1)),
                         HTRANS_SEQ);
      else idle_bus();
      hwdata = b2b_data[i];
      settle();
      chk("b2b_men", menable, 1);
      chk("b2b_maddr", maddress, 32'(4 * i));
      chk("b2b_wdata", mwritedata, b2b_data[i]);
      chk("b2b_hready", hready, 1);
      nxt_cyc();
    end
    settle();
    chk("b2b_end_men", menable, 0);

    // halfword lanes at offset 2
    addr_ph(1, HSIZE_HALF, BASE + 32'h6, HTRANS_NONSEQ);
    nxt_cyc();
    idle_bus();
    settle();
    chk("hw_be", mbyteen, 4'b1100);
    chk("hw_maddr", maddress, 32'h6);
    nxt_cyc();

    // out of range (first address past the span)
    addr_ph(0, HSIZE_WORD, BASE + SPAN, HTRANS_NONSEQ);
    nxt_cyc();
    idle_bus();
    settle();
    chk("oor_men", menable, 0);
    chk("oor_hresp", hresp, 1);
    nxt_cyc();
    nxt_cyc();

    // below base
    addr_ph(0, HSIZE_WORD, BASE - 32'h4, HTRANS_NONSEQ);
    nxt_cyc();
    idle_bus();
    settle();
    chk("low_hresp", hresp, 1);
    chk("low_hready", hready, 0);
    nxt_cyc();
    nxt_cyc();

    // doubleword on a 32-bit bus
    addr_ph(0, HSIZE_DWORD, BASE, HTRANS_NONSEQ);
    nxt_cyc();
    idle_bus();
    settle();
    chk("ovs_men", menable, 0);
    chk("ovs_hresp", hresp, 1);
    nxt_cyc();
    nxt_cyc();

    // memory error
    addr_ph(0, HSIZE_WORD, BASE + 32'h30, HTRANS_NONSEQ);
    merror = 1'b1;
    nxt_cyc();
    idle_bus();
    settle();
    chk("me_men", menable, 1);
    chk("me_hready", hready, 0);
    nxt_cyc();
    merror = 1'b0;
    settle();
    chk("me_e1_hready", hready, 0);
    chk("me_e1_hresp", hresp, 1);
    chk("me_e1_men", menable, 0);
    nxt_cyc();
    settle();
    chk("me_e2_hready", hready, 1);
    chk("me_e2_hresp", hresp, 1);
    nxt_cyc();

    // asynchronous reset in the middle of an access
    addr_ph(0, HSIZE_WORD, BASE + 32'h8, HTRANS_NONSEQ);
    mready = 1'b0;
    nxt_cyc();
    idle_bus();
    settle();
    chk("ar_pre_men", menable, 1);
    rst = 1'b1;
    #1;
    chk("ar_men", menable, 0);
    chk("ar_hready", hready, 1);
    chk("ar_hrdata", hrdata, 0);
    nxt_cyc();
    rst = 1'b0;
    nxt_cyc();
    settle();
    chk("ar_idle_hready", hready, 1);
    chk("ar_idle_hresp", hresp, 0);
    chk("ar_idle_men", menable, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
